// File: rtl/fir_pkg.sv
// Shared constants, FSM state encoding and the output round/saturate helper
// for the FIR tap reader.
package fir_pkg;

  localparam int TAPS   = 64;
  localparam int DATA_W = 16;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = 2 * DATA_W + ADDR_W;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    OUT    = 3'd4
  } state_e;

  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (DATA_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

  // Q2.30-style accumulator back to Q1.15: round half up, then clamp.
  function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = (acc + RND_BIAS) >>> (DATA_W - 1);
    if (shifted > SAT_MAX) begin
      round_sat = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      round_sat = SAT_MIN[DATA_W-1:0];
    end else begin
      round_sat = shifted[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_mac_dp.sv
// Multiply-accumulate datapath: registered product, accumulator with clear,
// and a rounded/saturated output register.
module fir_mac_dp
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr_i,
  input  logic              mul_en_i,
  input  logic              acc_en_i,
  input  logic              out_en_i,
  input  logic [DATA_W-1:0] samp_i,
  input  logic [DATA_W-1:0] coef_i,
  output logic [DATA_W-1:0] y_o
);

  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [DATA_W-1:0] y_d;
  logic        [DATA_W-1:0] y_q;

  // Operands widened first so the full product is formed at PROD_W bits.
  assign samp_ext = {{DATA_W{samp_i[DATA_W-1]}}, samp_i};
  assign coef_ext = {{DATA_W{coef_i[DATA_W-1]}}, coef_i};

  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    y_d    = y_q;
    if (mul_en_i) begin
      prod_d = samp_ext * coef_ext;
    end
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + {{ADDR_W{prod_q[PROD_W-1]}}, prod_q};
    end
    if (out_en_i) begin
      y_d = round_sat(acc_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod_q <= '0;
      acc_q  <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/fir_tap_reader.sv
// Walks all taps of the delay line per start pulse, driving read strobes and
// addresses, and emits one rounded/saturated filter output per computation.
module fir_tap_reader
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              samp_rd_en,
  output logic [ADDR_W-1:0] samp_addr,
  input  logic [DATA_W-1:0] samp_data,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              prod_vld_q;
  logic              prod_vld_d;
  logic              overrun_q;
  logic              overrun_d;
  logic              acc_clr;
  logic              in_run;
  logic              in_drain;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN1) || (state_q == DRAIN2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == ADDR_W'(TAPS - 1)) begin
          state_d = DRAIN1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN1: state_d = DRAIN2;
      DRAIN2: state_d = OUT;
      OUT: begin
        // A start here chains the next computation without an idle gap.
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign prod_vld_d = in_run;
  assign overrun_d  = overrun_q | (start & (in_run | in_drain));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_vld_q <= prod_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  // The accumulate lags the product register by one cycle; the final add
  // lands in DRAIN1 and DRAIN2 latches the rounded result for OUT.
  fir_mac_dp u_mac (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (acc_clr),
    .mul_en_i (in_run),
    .acc_en_i (prod_vld_q),
    .out_en_i (state_q == DRAIN2),
    .samp_i   (samp_data),
    .coef_i   (coef_data),
    .y_o      (y_out)
  );

  assign samp_rd_en = in_run;
  assign samp_addr  = in_run ? cnt_q : '0;
  assign coef_addr  = samp_addr;
  assign y_valid    = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_tap_reader.sv
// Randomized and directed bench for fir_tap_reader against a cycle-offset
// behavioural model of the filter computation.
module tb_fir_tap_reader;

  localparam int LAT = 67;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        samp_rd_en;
  logic [5:0]  samp_addr;
  logic [15:0] samp_data;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  logic [15:0] samp_mem [64];
  logic [15:0] coef_mem [64];

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int strobes = 0;

  // Model: t = cycles since accepted start (0 = idle), expected output/overrun.
  int          t = 0;
  logic [15:0] my = 16'h0;
  logic [15:0] pend = 16'h0;
  logic        mov = 1'b0;

  always #5 clk = ~clk;

  assign samp_data = samp_mem[samp_addr];
  assign coef_data = coef_mem[coef_addr];

  fir_tap_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .samp_rd_en (samp_rd_en),
    .samp_addr  (samp_addr),
    .samp_data  (samp_data),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [15:0] model_y();
    longint sum = 0;
    for (int k = 0; k < 64; k++) begin
      sum += longint'($signed(samp_mem[k])) * longint'($signed(coef_mem[k]));
    end
    sum = (sum + 64'sd16384) >>> 15;
    if (sum > 64'sd32767) sum = 64'sd32767;
    if (sum < -64'sd32768) sum = -64'sd32768;
    return sum[15:0];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t   = 0;
      my  = 16'h0;
      mov = 1'b0;
    end else begin
      edge_n++;
      if (start && (t == 0 || t == LAT)) begin
        t    = 1;
        pend = model_y();
      end else begin
        if (start) mov = 1'b1;
        if (t != 0 && t != LAT) t++;
        else t = 0;
      end
      if (t == LAT) my = pend;
    end
  end

  always @(negedge clk) begin
    logic       e_rd;
    logic [5:0] e_addr;
    e_rd   = (t >= 1 && t <= 64);
    e_addr = e_rd ? 6'(t - 1) : 6'd0;
    chk("samp_rd_en", 32'(samp_rd_en), 32'(e_rd));
    chk("samp_addr",  32'(samp_addr),  32'(e_addr));
    chk("coef_addr",  32'(coef_addr),  32'(e_addr));
    chk("y_valid",    32'(y_valid),    32'(t == LAT));
    chk("busy",       32'(busy),       32'(t != 0));
    chk("y_out",      32'(y_out),      32'(my));
    chk("overrun",    32'(overrun),    32'(mov));
    if (samp_rd_en) strobes++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start(output int n_start);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    n_start = edge_n;
  endtask

  task automatic wait_valid(input string name, input int n_start, output int lat);
    bit found = 0;
    for (int i = 0; i < 300; i++) begin
      if (y_valid) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    lat = edge_n - n_start + 1;
    if (!found) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    cyc(1);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) begin
      samp_mem[k] = 16'h0;
      coef_mem[k] = 16'h0;
    end
  endtask

  task automatic impulse_mem();
    clear_mem();
    for (int k = 0; k < 64; k++) coef_mem[k] = 16'(k * 256);
    samp_mem[5] = 16'h7FFF;
  endtask

  task automatic run_one(input string name, input logic [15:0] exp_y);
    int n0;
    int lat;
    strobes = 0;
    pulse_start(n0);
    wait_valid(name, n0, lat);
    chk({name, "_latency"}, 32'(lat), 32'(LAT));
    chk({name, "_y"}, 32'(y_out), 32'(exp_y));
    chk({name, "_strobes"}, 32'(strobes), 32'd64);
    $display("[TB] txn %s: y_out=0x%04h latency=%0d strobes=%0d", name, y_out, lat, strobes);
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int n0;
    int n1;
    int lat;
    int mode;
    clear_mem();
    resetn = 1'b0;
    start  = 1'b1;
    cyc(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_en", 32'(samp_rd_en), 32'd0);
    chk("reset_y_out", 32'(y_out), 32'd0);
    start  = 1'b0;
    resetn = 1'b1;
    cyc(2);

    impulse_mem();
    run_one("impulse", 16'h0500);

    for (int k = 0; k < 64; k++) begin
      samp_mem[k] = 16'h7FFF;
      coef_mem[k] = 16'h7FFF;
    end
    run_one("sat_pos", 16'h7FFF);
    for (int k = 0; k < 64; k++) samp_mem[k] = 16'h8000;
    run_one("sat_neg", 16'h8000);

    clear_mem();
    samp_mem[0] = 16'h0001;
    coef_mem[0] = 16'h4000;
    run_one("round_up", 16'h0001);
    coef_mem[0] = 16'h3FFF;
    run_one("round_down", 16'h0000);

    impulse_mem();
    pulse_start(n0);
    cyc(8);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_valid("overrun", n0, lat);
    chk("overrun_latency", 32'(lat), 32'(LAT));
    chk("overrun_y", 32'(y_out), 32'h0500);
    chk("overrun_flag", 32'(overrun), 32'd1);
    $display("[TB] txn overrun: y_out=0x%04h overrun=%0b", y_out, overrun);
    cyc(80);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    do_reset();
    pulse_start(n0);
    wait_valid("b2b_first", n0, lat);
    chk("b2b_first_latency", 32'(lat), 32'(LAT));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_valid("b2b_second", n0, lat);
    chk("b2b_second_latency", 32'(lat), 32'(2 * LAT));
    chk("b2b_y", 32'(y_out), 32'h0500);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    $display("[TB] txn back_to_back: second pulse at cycle %0d", lat);
    cyc(3);

    pulse_start(n0);
    cyc(28);
    resetn = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(samp_rd_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_y_out", 32'(y_out), 32'd0);
    $display("[TB] txn reset_mid_run: busy=%0b y_out=0x%04h", busy, y_out);
    cyc(2);
    resetn = 1'b1;
    cyc(2);
    run_one("post_reset", 16'h0500);

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 300 && t != 0; i++) cyc(1);
      for (int k = 0; k < 64; k++) begin
        samp_mem[k] = 16'($urandom);
        coef_mem[k] = 16'($signed(16'($urandom)) >>> $urandom_range(0, 6));
      end
      mode = $urandom_range(0, 2);
      pulse_start(n0);
      if (mode == 1) begin
        cyc($urandom_range(1, 60));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
      end
      wait_valid("rand", n0, lat);
      if (mode == 2) begin
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        n1 = edge_n;
        wait_valid("rand_b2b", n1, lat);
      end
      $display("[TB] txn random %0d mode=%0d y_out=0x%04h overrun=%0b", it, mode, y_out, overrun);
      cyc($urandom_range(0, 5));
    end
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
